fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Owns the framebuffer write port and shares it between two pixel writers: a CPU store path and a graphics engine. It also runs a built-in full-page clear engine. It manages double buffering by sending all writes to the back page and swapping pages only at the frame boundary reported by the display controller. The display read side reads the page selected by front_sel.

Parameters:
ADDR_W, 12, pixel address width within one page (row, col packed; 2^ADDR_W pixels per page)
DATA_W, 4, pixel data width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_valid  in  1  CPU write request
cpu_ready  out  1  CPU write accepted this cycle when cpu_valid&&cpu_ready
cpu_addr  in  ADDR_W  CPU pixel address
cpu_data  in  DATA_W  CPU pixel value
gfx_valid  in  1  graphics engine write request
gfx_ready  out  1  graphics write accepted this cycle when gfx_valid&&gfx_ready
gfx_addr  in  ADDR_W  graphics pixel address
gfx_data  in  DATA_W  graphics pixel value
clr_start  in  1  one-cycle pulse: fill back page with clr_value
clr_value  in  DATA_W  fill value, sampled on accepted clr_start
clr_busy  out  1  clear in progress
swap_req  in  1  one-cycle pulse: request page swap at next frame boundary
frame_done  in  1  one-cycle pulse from display controller after latching the last row
swap_pending  out  1  swap requested, not yet performed
front_sel  out  1  page currently displayed; the read side uses it as address MSB
fb_we  out  1  framebuffer write enable (registered)
fb_waddr  out  ADDR_W+1  {back page, pixel address} (registered)
fb_din  out  DATA_W  write data (registered)

Behaviour:
- Reset values: state IDLE, fb_we=0, fb_waddr=0, fb_din=0, clr_busy=0, swap_pending=0, front_sel=0, last_grant=GFX. cpu_ready and gfx_ready are 0 while rst is high.
- States: IDLE (serve requesters) and CLEAR (sweep the page).
- IDLE arbitration is combinational into the ready outputs:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last wins; last_grant updates on each transfer.
  - After reset, the CPU wins the first tie.
- At most one transfer per cycle.
- Write latency: a transfer in cycle N gives fb_we=1 in cycle N+1, with fb_waddr={~front_sel sampled in cycle N, addr} and fb_din=data. With no transfer, fb_we=0 next cycle.
- Requesters must hold valid, addr and data stable until accepted. Deasserting valid without a transfer is allowed.
- clr_start in IDLE has priority over requesters: both readies are 0 that cycle. The block then:
  - latches clr_value and the target page ~front_sel;
  - goes to CLEAR with clr_busy=1 from the next cycle;
  - in CLEAR, issues one write per cycle to addresses 0..2^ADDR_W-1 in ascending order, all on the latched page;
  - holds both readies at 0 throughout.
- The last clear write (address all-ones) is followed by a return to IDLE with clr_busy=0. The clear takes exactly 2^ADDR_W write cycles.
- clr_start while in CLEAR is ignored and does not restart the sweep.
- swap_req sets swap_pending; further swap_req pulses while pending have no extra effect.
- Page swap: front_sel toggles and swap_pending clears on the cycle after frame_done=1 when all of the following hold:
  - swap_pending=1 or swap_req=1 that cycle (simultaneous pulses count);
  - state is not CLEAR, and clr_start is not being accepted.
- If frame_done arrives during a clear, the swap stays pending until a later frame_done after the clear has finished.
- A transfer in the same cycle as the toggle decision uses the pre-toggle back page.
- frame_done with nothing pending: no effect.
- Reset asserted mid-clear or mid-transfer: everything returns to reset values immediately. The partial clear is abandoned and is not resumed.

Decomposition:
- Shared package (led_pkg): state enum {IDLE, CLEAR}, grant enum {CPU, GFX}, and constants PAGE_ADDR_W=12 and PIX_W=4, also used by the LED controller and framebuffer.
- One natural sub-module: rr_arbiter2, a two-requester round-robin with a last-grant register. The page/swap logic and the clear counter stay in the top module.

Test Plan:
- CPU only: cpu_valid with addr=0x123, data=0x5 at front_sel=0 -> cpu_ready=1 same cycle; next cycle fb_we=1, fb_waddr=0x1123, fb_din=0x5.
- Both requesters valid for 4 cycles after reset -> grants in order CPU, GFX, CPU, GFX; exactly one fb_we per cycle.
- clr_start with clr_value=0xA -> clr_busy high for 4096 cycles; fb_waddr sweeps 0x1000..0x1FFF with fb_din=0xA; readies 0 throughout; state back to IDLE afterwards.
- swap_req, then frame_done 10 cycles later -> swap_pending=1 for those 10 cycles; front_sel 0->1 after frame_done; the next CPU write to addr 0x001 gives fb_waddr=0x0001.
- swap_req and frame_done in the same cycle, and frame_done during a clear -> first case swaps immediately; second case holds swap_pending until the first frame_done after clr_busy falls.
- rst asserted at clear address 0x200 -> clr_busy=0, fb_we=0, front_sel and swap_pending cleared in the same cycle; the clear is not resumed after reset releases.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Types and constants shared by the framebuffer write arbiter,
//               the LED controller and the framebuffer itself.
//               - state_t     : write-port owner state (IDLE / CLEAR)
//               - grant_t     : round-robin grant identity (CPU / GFX)
//               - PAGE_ADDR_W : pixel address width within one page
//               - PIX_W       : pixel data width
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int PAGE_ADDR_W = 12;
    localparam int PIX_W       = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        CPU = 1'b0,
        GFX = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter with a last-grant register.
//               Grants are combinational. On a tie the requester that was not
//               granted last wins. The CPU wins the first tie after reset.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               en           - arbitration allowed this cycle
//               req_cpu/gfx  - requests
//               gnt_cpu/gfx  - grants (a grant is a completed transfer)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import led_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_cpu,
    input  logic req_gfx,
    output logic gnt_cpu,
    output logic gnt_gfx
);

    grant_t r_last;
    logic   w_gnt_cpu;
    logic   w_gnt_gfx;

    // Grants are forced low while reset is held so nothing is accepted.
    assign w_gnt_cpu = en && !rst && req_cpu && (!req_gfx || (r_last == GFX));
    assign w_gnt_gfx = en && !rst && req_gfx && (!req_cpu || (r_last == CPU));

    assign gnt_cpu = w_gnt_cpu;
    assign gnt_gfx = w_gnt_gfx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= GFX;
        end else if (w_gnt_cpu) begin
            r_last <= CPU;
        end else if (w_gnt_gfx) begin
            r_last <= GFX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Owns the framebuffer write port. Shares it between a CPU and a
//               graphics engine, runs a full back-page clear engine, and
//               manages double buffering (writes go to the back page, pages
//               swap on the display controller's frame boundary).
// Ports       : clk, rst                 - clock, async active-high reset
//               cpu_* / gfx_*            - valid/ready pixel write requesters
//               clr_start/value/busy     - back-page clear engine
//               swap_req/frame_done      - swap request / frame boundary
//               swap_pending, front_sel  - swap status, displayed page
//               fb_we/fb_waddr/fb_din    - registered framebuffer write port
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter
    import led_pkg::*;
#(
    parameter int ADDR_W = PAGE_ADDR_W,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              gfx_valid,
    output logic              gfx_ready,
    input  logic [ADDR_W-1:0] gfx_addr,
    input  logic [DATA_W-1:0] gfx_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    input  logic              swap_req,
    input  logic              frame_done,
    output logic              swap_pending,
    output logic              front_sel,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_waddr,
    output logic [DATA_W-1:0] fb_din
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_clr_val;
    logic              r_clr_page;
    logic              r_front;
    logic              r_pending;
    logic              r_we;
    logic [ADDR_W:0]   r_waddr;
    logic [DATA_W-1:0] r_din;

    logic w_idle;
    logic w_arb_en;
    logic w_gnt_cpu;
    logic w_gnt_gfx;
    logic w_swap;

    assign w_idle   = (r_state == IDLE);
    // A clear start in IDLE takes the cycle away from both requesters.
    assign w_arb_en = w_idle && !clr_start;

    // Swap is blocked during a clear and on the cycle a clear is accepted, so
    // the clear never has its target page turned into the displayed page.
    assign w_swap = frame_done && (r_pending || swap_req) && w_idle && !clr_start;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (w_arb_en),
        .req_cpu (cpu_valid),
        .req_gfx (gfx_valid),
        .gnt_cpu (w_gnt_cpu),
        .gnt_gfx (w_gnt_gfx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_clr_val  <= '0;
            r_clr_page <= 1'b0;
            r_front    <= 1'b0;
            r_pending  <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_din      <= '0;
        end else begin
            r_we <= 1'b0;

            if (r_state == CLEAR) begin
                r_we      <= 1'b1;
                r_waddr   <= {r_clr_page, r_clr_cnt};
                r_din     <= r_clr_val;
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                if (&r_clr_cnt) begin
                    r_state <= IDLE;
                end
            end else if (clr_start) begin
                r_state    <= CLEAR;
                r_clr_cnt  <= '0;
                r_clr_val  <= clr_value;
                r_clr_page <= ~r_front;
            end else if (w_gnt_cpu) begin
                r_we    <= 1'b1;
                r_waddr <= {~r_front, cpu_addr};
                r_din   <= cpu_data;
            end else if (w_gnt_gfx) begin
                r_we    <= 1'b1;
                r_waddr <= {~r_front, gfx_addr};
                r_din   <= gfx_data;
            end

            // A same-cycle transfer above already used the pre-toggle page.
            if (w_swap) begin
                r_front   <= ~r_front;
                r_pending <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign cpu_ready    = w_gnt_cpu;
    assign gfx_ready    = w_gnt_gfx;
    assign clr_busy     = (r_state == CLEAR);
    assign swap_pending = r_pending;
    assign front_sel    = r_front;
    assign fb_we        = r_we;
    assign fb_waddr     = r_waddr;
    assign fb_din       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Directed self-checking bench for fb_write_arbiter. Inputs are
//               driven 1 time unit after the rising edge, outputs are sampled
//               on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int AW = 12;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid, cpu_ready, gfx_valid, gfx_ready;
    logic [AW-1:0] cpu_addr, gfx_addr;
    logic [DW-1:0] cpu_data, gfx_data, clr_value, fb_din;
    logic          clr_start, clr_busy, swap_req, frame_done;
    logic          swap_pending, front_sel, fb_we;
    logic [AW:0]   fb_waddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .gfx_valid    (gfx_valid),
        .gfx_ready    (gfx_ready),
        .gfx_addr     (gfx_addr),
        .gfx_data     (gfx_data),
        .clr_start    (clr_start),
        .clr_value    (clr_value),
        .clr_busy     (clr_busy),
        .swap_req     (swap_req),
        .frame_done   (frame_done),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .fb_we        (fb_we),
        .fb_waddr     (fb_waddr),
        .fb_din       (fb_din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int bad_busy, bad_rdy, bad_wr;

        rst        = 1'b1;
        cpu_valid  = 1'b1;
        gfx_valid  = 1'b1;
        cpu_addr   = 12'h123;
        cpu_data   = 4'h5;
        gfx_addr   = 12'h456;
        gfx_data   = 4'h7;
        clr_start  = 1'b0;
        clr_value  = 4'h0;
        swap_req   = 1'b0;
        frame_done = 1'b0;

        // Reset state, with both requesters asserting.
        smp();
        smp();
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("rst_gfx_ready", 32'(gfx_ready), 32'h0);
        chk("rst_fb_we", 32'(fb_we), 32'h0);
        chk("rst_fb_waddr", 32'(fb_waddr), 32'h0);
        chk("rst_fb_din", 32'(fb_din), 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_swap_pending", 32'(swap_pending), 32'h0);
        chk("rst_front_sel", 32'(front_sel), 32'h0);

        // Tie for 4 cycles: CPU, GFX, CPU, GFX.
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("tie_cpu_ready", 32'(cpu_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("tie_gfx_ready", 32'(gfx_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            if (i > 0) begin
                chk("tie_fb_we", 32'(fb_we), 32'h1);
                chk("tie_fb_din", 32'(fb_din), (i % 2 == 1) ? 32'h5 : 32'h7);
            end
            nxt();
        end
        cpu_valid = 1'b0;
        gfx_valid = 1'b0;
        smp();
        chk("tie_last_we", 32'(fb_we), 32'h1);
        chk("tie_last_waddr", 32'(fb_waddr), 32'h1456);
        chk("tie_last_din", 32'(fb_din), 32'h7);
        nxt();
        smp();
        chk("idle_fb_we", 32'(fb_we), 32'h0);

        // CPU only.
        nxt();
        cpu_valid = 1'b1;
        smp();
        chk("cpu_only_ready", 32'(cpu_ready), 32'h1);
        chk("cpu_only_gfx_ready", 32'(gfx_ready), 32'h0);
        nxt();
        cpu_valid = 1'b0;
        smp();
        chk("cpu_only_we", 32'(fb_we), 32'h1);
        chk("cpu_only_waddr", 32'(fb_waddr), 32'h1123);
        chk("cpu_only_din", 32'(fb_din), 32'h5);

        // frame_done with nothing pending.
        nxt();
        frame_done = 1'b1;
        smp();
        nxt();
        frame_done = 1'b0;
        smp();
        chk("fd_idle_front", 32'(front_sel), 32'h0);
        chk("fd_idle_pending", 32'(swap_pending), 32'h0);

        // swap_req, frame_done 10 cycles later with a CPU write in that cycle.
        nxt();
        swap_req = 1'b1;
        smp();
        nxt();
        swap_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                frame_done = 1'b1;
                cpu_valid  = 1'b1;
                cpu_addr   = 12'h001;
                cpu_data   = 4'h3;
            end
            smp();
            chk("swap_wait_pending", 32'(swap_pending), 32'h1);
            chk("swap_wait_front", 32'(front_sel), 32'h0);
            nxt();
        end
        frame_done = 1'b0;
        smp();
        chk("swap_front", 32'(front_sel), 32'h1);
        chk("swap_pending_clr", 32'(swap_pending), 32'h0);
        chk("swap_pretoggle_waddr", 32'(fb_waddr), 32'h1001);
        nxt();
        cpu_valid = 1'b0;
        smp();
        chk("swap_post_waddr", 32'(fb_waddr), 32'h0001);
        chk("swap_post_din", 32'(fb_din), 32'h3);

        // Simultaneous swap_req and frame_done swap immediately.
        nxt();
        swap_req   = 1'b1;
        frame_done = 1'b1;
        smp();
        nxt();
        swap_req   = 1'b0;
        frame_done = 1'b0;
        smp();
        chk("simul_front", 32'(front_sel), 32'h0);
        chk("simul_pending", 32'(swap_pending), 32'h0);

        // Full clear with both requesters waiting; swap requested mid-clear.
        nxt();
        clr_start = 1'b1;
        clr_value = 4'hA;
        cpu_valid = 1'b1;
        cpu_addr  = 12'h123;
        cpu_data  = 4'h5;
        gfx_valid = 1'b1;
        smp();
        chk("clr_accept_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("clr_accept_gfx_ready", 32'(gfx_ready), 32'h0);
        nxt();
        clr_start = 1'b0;
        bad_busy = 0;
        bad_rdy  = 0;
        bad_wr   = 0;
        for (int n = 1; n <= 4096; n++) begin
            swap_req   = (n == 50);
            frame_done = (n == 60);
            clr_start  = (n == 100);
            if (n == 100) clr_value = 4'h3;
            smp();
            if (clr_busy !== 1'b1) bad_busy++;
            if (cpu_ready !== 1'b0 || gfx_ready !== 1'b0) bad_rdy++;
            if (n == 1) begin
                if (fb_we !== 1'b0) bad_wr++;
            end else if (fb_we !== 1'b1 || fb_waddr !== 13'(32'h1000 + n - 2) || fb_din !== 4'hA) begin
                bad_wr++;
            end
            nxt();
        end
        swap_req   = 1'b0;
        frame_done = 1'b0;
        clr_start  = 1'b0;
        chk("clr_busy_cycles_bad", 32'(bad_busy), 32'h0);
        chk("clr_ready_bad", 32'(bad_rdy), 32'h0);
        chk("clr_sweep_bad", 32'(bad_wr), 32'h0);
        smp();
        chk("clr_done_busy", 32'(clr_busy), 32'h0);
        chk("clr_last_we", 32'(fb_we), 32'h1);
        chk("clr_last_waddr", 32'(fb_waddr), 32'h1FFF);
        chk("clr_last_din", 32'(fb_din), 32'hA);
        chk("clr_done_gfx_ready", 32'(gfx_ready), 32'h1);
        chk("clr_done_cpu_ready", 32'(cpu_ready), 32'h0);
        chk("clr_hold_pending", 32'(swap_pending), 32'h1);
        chk("clr_hold_front", 32'(front_sel), 32'h0);
        nxt();
        cpu_valid = 1'b0;
        gfx_valid = 1'b0;
        smp();
        chk("post_clr_gfx_waddr", 32'(fb_waddr), 32'h1456);
        chk("post_clr_gfx_din", 32'(fb_din), 32'h7);

        // First frame_done after the clear performs the held swap.
        nxt();
        frame_done = 1'b1;
        smp();
        chk("held_swap_pre_front", 32'(front_sel), 32'h0);
        nxt();
        frame_done = 1'b0;
        smp();
        chk("held_swap_front", 32'(front_sel), 32'h1);
        chk("held_swap_pending", 32'(swap_pending), 32'h0);

        // Reset mid-clear at address 0x200 (back page is now 0).
        nxt();
        swap_req = 1'b1;
        smp();
        nxt();
        swap_req  = 1'b0;
        clr_start = 1'b1;
        clr_value = 4'h6;
        smp();
        nxt();
        clr_start = 1'b0;
        repeat (32'h201) begin
            smp();
            nxt();
        end
        smp();
        chk("midclr_waddr", 32'(fb_waddr), 32'h0200);
        chk("midclr_din", 32'(fb_din), 32'h6);
        chk("midclr_busy", 32'(clr_busy), 32'h1);
        chk("midclr_pending", 32'(swap_pending), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(clr_busy), 32'h0);
        chk("async_rst_we", 32'(fb_we), 32'h0);
        chk("async_rst_waddr", 32'(fb_waddr), 32'h0);
        chk("async_rst_front", 32'(front_sel), 32'h0);
        chk("async_rst_pending", 32'(swap_pending), 32'h0);
        nxt();
        nxt();
        rst = 1'b0;
        repeat (5) nxt();
        smp();
        chk("no_resume_busy", 32'(clr_busy), 32'h0);
        chk("no_resume_we", 32'(fb_we), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
